// File: rtl/spi_master_param.sv
`default_nettype none
// spi_master_param: full-duplex SPI master with DATA_W-bit frames, all four SPI modes,
// selectable bit order and NUM_CS active-low chip selects; sclk is a clk-driven register.
module spi_master_param #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b1,
  parameter int NUM_CS    = 1,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic [CS_W-1:0]   cs_sel,
  output logic              ready,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  logic [1:0]        state;
  logic [TICK_W-1:0] tick;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [NUM_CS-1:0] cs_dec;

  logic              tick_end;
  logic              do_edge;
  logic              leading;
  logic              drive_bit;
  logic              sample_bit;
  logic              next_bit;
  logic              din_first;
  logic [DATA_W-1:0] din_rest;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;

  // Out-of-range indices match no slot, so every select stays high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // edge_cnt is the index of the next sclk edge; even indices are leading edges.
  assign tick_end   = (tick == TICK_LAST);
  assign do_edge    = tick_end && ((state == S_START) ||
                                   ((state == S_SHIFT) && (edge_cnt != EDGE_LAST)));
  assign leading    = ~edge_cnt[0];
  assign drive_bit  = do_edge && (CPHA ? leading
                                       : (!leading && (edge_cnt != (EDGE_LAST - 1'b1))));
  assign sample_bit = do_edge && (CPHA ? !leading : leading);

  assign next_bit  = LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1];
  assign tx_next   = LSB_FIRST ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
  assign rx_next   = LSB_FIRST ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
  assign din_first = LSB_FIRST ? din[0] : din[DATA_W-1];
  assign din_rest  = LSB_FIRST ? {1'b0, din[DATA_W-1:1]} : {din[DATA_W-2:0], 1'b0};

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick     <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL;
      cs       <= '1;
      mosi     <= 1'b0;
      dout     <= '0;
      done     <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (newd) begin
            state    <= S_START;
            tick     <= '0;
            edge_cnt <= '0;
            cs       <= cs_dec;
            rx_sh    <= '0;
            // CPHA=0 slaves sample on the first edge, so bit 0 must already be on the wire.
            if (!CPHA) begin
              mosi  <= din_first;
              tx_sh <= din_rest;
            end else begin
              tx_sh <= din;
            end
          end
        end
        S_START, S_SHIFT: begin
          if (!tick_end) begin
            tick <= tick + 1'b1;
          end else begin
            tick <= '0;
            if ((state == S_SHIFT) && (edge_cnt == EDGE_LAST)) begin
              state <= S_STOP;
              cs    <= '1;
              mosi  <= 1'b0;
              done  <= 1'b1;
              dout  <= rx_sh;
            end else begin
              state    <= S_SHIFT;
              sclk     <= ~sclk;
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
          if (drive_bit) begin
            mosi  <= next_bit;
            tx_sh <= tx_next;
          end
          if (sample_bit) rx_sh <= rx_next;
        end
        S_STOP: begin
          if (!tick_end) begin
            tick <= tick + 1'b1;
          end else begin
            tick  <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// tb_spi_master_param: directed self-checking bench over three parameterisations
// of spi_master_param (mode 0 / mode 3 MSB-first with 4 selects / CLK_DIV=1 with 3 selects).
module tb_spi_master_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // u0: defaults, loopback
  logic        rst0_n, newd0, ready0, busy0, sclk0, mosi0, miso0, done0;
  logic [11:0] din0, dout0;
  logic [0:0]  cs_sel0, cs0;
  assign miso0 = mosi0;

  // u1: CPOL=1, CPHA=1, MSB first, 4 selects, miso held high
  logic        rst12_n, newd1, ready1, busy1, sclk1, mosi1, miso1, done1;
  logic [11:0] din1, dout1;
  logic [1:0]  cs_sel1;
  logic [3:0]  cs1;

  // u2: DATA_W=8, CLK_DIV=1, 3 selects, loopback
  logic        newd2, ready2, busy2, sclk2, mosi2, miso2, done2;
  logic [7:0]  din2, dout2;
  logic [1:0]  cs_sel2;
  logic [2:0]  cs2;
  assign miso2 = mosi2;

  spi_master_param u0 (
    .clk(clk), .rst_n(rst0_n), .newd(newd0), .din(din0), .cs_sel(cs_sel0),
    .ready(ready0), .busy(busy0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso0), .dout(dout0), .done(done0)
  );

  spi_master_param #(
    .DATA_W(12), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0), .NUM_CS(4)
  ) u1 (
    .clk(clk), .rst_n(rst12_n), .newd(newd1), .din(din1), .cs_sel(cs_sel1),
    .ready(ready1), .busy(busy1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso1), .dout(dout1), .done(done1)
  );

  spi_master_param #(
    .DATA_W(8), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1), .NUM_CS(3)
  ) u2 (
    .clk(clk), .rst_n(rst12_n), .newd(newd2), .din(din2), .cs_sel(cs_sel2),
    .ready(ready2), .busy(busy2), .sclk(sclk2), .cs(cs2), .mosi(mosi2),
    .miso(miso2), .dout(dout2), .done(done2)
  );

  // Hand-derived bit sequences on the leading edges
  logic seq_a5c [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic seq_801 [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst12_n = 1'b0;
    newd0 = 1'b0; din0 = '0; cs_sel0 = '0;
    newd1 = 1'b0; din1 = '0; cs_sel1 = '0; miso1 = 1'b1;
    newd2 = 1'b0; din2 = '0; cs_sel2 = '0;

    // Reset state
    #12;
    check("rst_ready0", ready0, 1);
    check("rst_busy0",  busy0,  0);
    check("rst_sclk0",  sclk0,  0);
    check("rst_cs0",    cs0,    1);
    check("rst_mosi0",  mosi0,  0);
    check("rst_done0",  done0,  0);
    check("rst_dout0",  dout0,  0);
    check("rst_sclk1",  sclk1,  1);
    check("rst_cs1",    cs1,    4'hF);
    check("rst_cs2",    cs2,    3'h7);
    @(posedge clk);
    #1;
    rst0_n = 1'b1; rst12_n = 1'b1;
    step(); step();
    check("post_rst_ready0", ready0, 1);

    // Mode 0, LSB first, loopback of 12'hA5C
    din0 = 12'hA5C; cs_sel0 = 1'b0; newd0 = 1'b1; cyc = 0;
    step(); newd0 = 1'b0;
    check("t1_start_cs",    cs0,    0);
    check("t1_start_ready", ready0, 0);
    check("t1_start_busy",  busy0,  1);
    check("t1_start_mosi",  mosi0,  0);
    check("t1_start_sclk",  sclk0,  0);
    for (int j = 0; j < 12; j++) begin
      go_to(5 + 8 * j);
      check($sformatf("t1_lead_sclk[%0d]", j), sclk0, 1);
      check($sformatf("t1_lead_mosi[%0d]", j), mosi0, seq_a5c[j]);
      go_to(9 + 8 * j);
      check($sformatf("t1_trail_sclk[%0d]", j), sclk0, 0);
    end
    go_to(100);
    check("t1_done_early", done0, 0);
    go_to(101);
    check("t1_done",      done0, 1);
    check("t1_dout",      dout0, 12'hA5C);
    check("t1_stop_cs",   cs0,   1);
    check("t1_stop_mosi", mosi0, 0);
    check("t1_stop_sclk", sclk0, 0);
    go_to(102);
    check("t1_done_pulse", done0, 0);
    go_to(104);
    check("t1_ready_early", ready0, 0);
    go_to(105);
    check("t1_ready", ready0, 1);

    // newd held high: one accept per frame, din changes mid-frame ignored
    din0 = 12'h3A7; newd0 = 1'b1; cyc = 0;
    step();
    check("t2_cs_f1", cs0, 0);
    go_to(50);
    din0 = 12'h0F0;
    go_to(101);
    check("t2_done_f1", done0, 1);
    check("t2_dout_f1", dout0, 12'h3A7);
    go_to(104);
    check("t2_gap_cs_stop",  cs0,    1);
    check("t2_gap_ready_st", ready0, 0);
    go_to(105);
    check("t2_gap_cs_idle", cs0,    1);
    check("t2_gap_ready",   ready0, 1);
    go_to(106);
    check("t2_cs_f2",    cs0,    0);
    check("t2_busy_f2",  ready0, 0);
    newd0 = 1'b0;
    go_to(206);
    check("t2_done_f2", done0, 1);
    check("t2_dout_f2", dout0, 12'h0F0);
    go_to(216);
    check("t2_no_third_ready", ready0, 1);
    check("t2_no_third_cs",    cs0,    1);

    // Reset asserted after edge 9 of a frame
    din0 = 12'hFFF; newd0 = 1'b1; cyc = 0;
    step(); newd0 = 1'b0;
    go_to(41);
    check("t3_pre_cs",   cs0,   0);
    check("t3_pre_mosi", mosi0, 1);
    #2;
    rst0_n = 1'b0;
    #1;
    check("t3_async_sclk",  sclk0,  0);
    check("t3_async_cs",    cs0,    1);
    check("t3_async_mosi",  mosi0,  0);
    check("t3_async_ready", ready0, 1);
    check("t3_async_dout",  dout0,  0);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("t3_no_done[%0d]", j), done0, 0);
    end
    rst0_n = 1'b1;
    step();
    din0 = 12'h5A3; newd0 = 1'b1; cyc = 0;
    step(); newd0 = 1'b0;
    check("t3_retry_cs", cs0, 0);
    go_to(101);
    check("t3_retry_done", done0, 1);
    check("t3_retry_dout", dout0, 12'h5A3);
    go_to(105);

    // Mode 3, MSB first, cs_sel=2 of 4, miso high
    din1 = 12'h801; cs_sel1 = 2'd2; newd1 = 1'b1; cyc = 0;
    step(); newd1 = 1'b0;
    check("t4_start_cs",   cs1,   4'b1011);
    check("t4_start_sclk", sclk1, 1);
    for (int j = 0; j < 12; j++) begin
      go_to(5 + 8 * j);
      check($sformatf("t4_lead_sclk[%0d]", j), sclk1, 0);
      check($sformatf("t4_lead_mosi[%0d]", j), mosi1, seq_801[j]);
      go_to(9 + 8 * j);
      check($sformatf("t4_trail_sclk[%0d]", j), sclk1, 1);
    end
    go_to(100);
    check("t4_frame_cs", cs1,   4'b1011);
    check("t4_no_done",  done1, 0);
    go_to(101);
    check("t4_done",    done1, 1);
    check("t4_dout",    dout1, 12'hFFF);
    check("t4_stop_cs", cs1,   4'hF);
    check("t4_idle_sclk", sclk1, 1);
    go_to(105);
    check("t4_ready", ready1, 1);

    // CLK_DIV=1, 8-bit loopback, cs_sel=1 of 3; newd while busy ignored
    din2 = 8'h3C; cs_sel2 = 2'd1; newd2 = 1'b1; cyc = 0;
    step(); newd2 = 1'b0;
    check("t5_start_cs",   cs2,   3'b101);
    check("t5_start_mosi", mosi2, 0);
    check("t5_start_sclk", sclk2, 0);
    go_to(2);
    check("t5_edge0_sclk", sclk2, 1);
    go_to(3);
    check("t5_edge1_sclk", sclk2, 0);
    go_to(5);
    din2 = 8'hFF; cs_sel2 = 2'd0; newd2 = 1'b1;
    go_to(6);
    newd2 = 1'b0;
    check("t5_busy_cs", cs2, 3'b101);
    go_to(17);
    check("t5_done_early", done2, 0);
    go_to(18);
    check("t5_done",    done2, 1);
    check("t5_dout",    dout2, 8'h3C);
    check("t5_stop_cs", cs2,   3'h7);
    go_to(19);
    check("t5_done_pulse", done2, 0);
    check("t5_ready",      ready2, 1);

    // Out-of-range select: no cs asserts, frame still runs
    din2 = 8'hA1; cs_sel2 = 2'd3; newd2 = 1'b1; cyc = 0;
    step(); newd2 = 1'b0;
    check("t6_start_cs",   cs2,   3'h7);
    check("t6_start_busy", busy2, 1);
    go_to(9);
    check("t6_mid_cs", cs2, 3'h7);
    go_to(18);
    check("t6_done", done2, 1);
    check("t6_dout", dout2, 8'hA1);
    go_to(19);
    check("t6_ready", ready2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
